// File: rtl/character_position_file.sv
// Register file of (x, y) pixel positions for pacman (index 0) and the ghosts,
// with read / write / clamped single-step ops. Define COLLISION_DETECT_EN to build ghost-vs-pacman comparators.
module character_position_file #(
    parameter int NUM_CHARS = 5,
    parameter int SEL_W     = 3,
    parameter int COORD_W   = 8,
    parameter int MAX_X     = 159,
    parameter int MAX_Y     = 119,
    parameter int STEP      = 1,
    parameter int PAC_X     = 10,
    parameter int PAC_Y     = 10,
    parameter int GHOST_X0  = 40,
    parameter int GHOST_DX  = 5,
    parameter int GHOST_Y   = 35
) (
    input  logic                 clock_50,
    input  logic                 reset,
    input  logic [1:0]           op,
    input  logic [SEL_W-1:0]     char_sel,
    input  logic [COORD_W-1:0]   x_in,
    input  logic [COORD_W-1:0]   y_in,
    input  logic [1:0]           dir,
    output logic [COORD_W-1:0]   x_out,
    output logic [COORD_W-1:0]   y_out,
    output logic                 rd_valid,
    output logic                 clamped,
    output logic                 err,
    output logic [NUM_CHARS-2:0] collision
);

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_STEP  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   wide_t;

    localparam coord_t MAX_X_C = coord_t'(MAX_X);
    localparam coord_t MAX_Y_C = coord_t'(MAX_Y);
    localparam wide_t  MAX_X_W = wide_t'(MAX_X);
    localparam wide_t  MAX_Y_W = wide_t'(MAX_Y);
    localparam wide_t  STEP_W  = wide_t'(STEP);

    function automatic coord_t reset_x(input int unsigned idx);
        if (idx == 0) return coord_t'(PAC_X);
        return coord_t'(GHOST_X0 + int'(idx - 1) * GHOST_DX);
    endfunction

    function automatic coord_t reset_y(input int unsigned idx);
        if (idx == 0) return coord_t'(PAC_Y);
        return coord_t'(GHOST_Y);
    endfunction

    op_e  op_s;
    dir_e dir_s;
    assign op_s  = op_e'(op);
    assign dir_s = dir_e'(dir);

    coord_t x_q [NUM_CHARS];
    coord_t y_q [NUM_CHARS];
    coord_t x_d [NUM_CHARS];
    coord_t y_d [NUM_CHARS];

    coord_t                x_out_q, x_out_d;
    coord_t                y_out_q, y_out_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  clamped_q, clamped_d;
    logic                  err_q, err_d;
    logic [NUM_CHARS-2:0]  collision_q, collision_d;

    logic   sel_ok;
    coord_t cur_x, cur_y;
    coord_t step_x, step_y;
    logic   step_clamp;
    coord_t wr_x, wr_y;
    logic   wr_clamp;

    // Selected entry; an index outside the file leaves sel_ok low.
    always_comb begin
        sel_ok = 1'b0;
        cur_x  = '0;
        cur_y  = '0;
        for (int unsigned i = 0; i < NUM_CHARS; i++) begin
            if (char_sel == SEL_W'(i)) begin
                sel_ok = 1'b1;
                cur_x  = x_q[i];
                cur_y  = y_q[i];
            end
        end
    end

    // One extra bit keeps the +STEP compare free of wrap-around.
    always_comb begin
        step_x     = cur_x;
        step_y     = cur_y;
        step_clamp = 1'b0;
        case (dir_s)
            DIR_UP: begin
                if ({1'b0, cur_y} < STEP_W) begin
                    step_y     = '0;
                    step_clamp = 1'b1;
                end else begin
                    step_y = coord_t'({1'b0, cur_y} - STEP_W);
                end
            end
            DIR_DOWN: begin
                if ({1'b0, cur_y} + STEP_W > MAX_Y_W) begin
                    step_y     = MAX_Y_C;
                    step_clamp = 1'b1;
                end else begin
                    step_y = coord_t'({1'b0, cur_y} + STEP_W);
                end
            end
            DIR_LEFT: begin
                if ({1'b0, cur_x} < STEP_W) begin
                    step_x     = '0;
                    step_clamp = 1'b1;
                end else begin
                    step_x = coord_t'({1'b0, cur_x} - STEP_W);
                end
            end
            DIR_RIGHT: begin
                if ({1'b0, cur_x} + STEP_W > MAX_X_W) begin
                    step_x     = MAX_X_C;
                    step_clamp = 1'b1;
                end else begin
                    step_x = coord_t'({1'b0, cur_x} + STEP_W);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_x     = (x_in > MAX_X_C) ? MAX_X_C : x_in;
        wr_y     = (y_in > MAX_Y_C) ? MAX_Y_C : y_in;
        wr_clamp = (x_in > MAX_X_C) || (y_in > MAX_Y_C);
    end

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        x_out_d    = x_out_q;
        y_out_d    = y_out_q;
        rd_valid_d = 1'b0;
        clamped_d  = 1'b0;
        err_d      = 1'b0;
        if (op_s != OP_NOP && !sel_ok) begin
            err_d = 1'b1;
        end else begin
            case (op_s)
                OP_READ: begin
                    rd_valid_d = 1'b1;
                    x_out_d    = cur_x;
                    y_out_d    = cur_y;
                end
                OP_WRITE: begin
                    for (int unsigned i = 0; i < NUM_CHARS; i++) begin
                        if (char_sel == SEL_W'(i)) begin
                            x_d[i] = wr_x;
                            y_d[i] = wr_y;
                        end
                    end
                    clamped_d = wr_clamp;
                end
                OP_STEP: begin
                    for (int unsigned i = 0; i < NUM_CHARS; i++) begin
                        if (char_sel == SEL_W'(i)) begin
                            x_d[i] = step_x;
                            y_d[i] = step_y;
                        end
                    end
                    rd_valid_d = 1'b1;
                    clamped_d  = step_clamp;
                    x_out_d    = step_x;
                    y_out_d    = step_y;
                end
                default: ;
            endcase
        end
    end

`ifdef COLLISION_DETECT_EN
    // Compares pre-edge contents, so the flag trails a position change by one cycle.
    always_comb begin
        collision_d = '0;
        for (int unsigned i = 1; i < NUM_CHARS; i++) begin
            collision_d[i-1] = (x_q[i] == x_q[0]) && (y_q[i] == y_q[0]);
        end
    end
`else
    always_comb begin
        collision_d = '0;
    end
`endif

    always_ff @(posedge clock_50) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CHARS; i++) begin
                x_q[i] <= reset_x(i);
                y_q[i] <= reset_y(i);
            end
            x_out_q     <= '0;
            y_out_q     <= '0;
            rd_valid_q  <= 1'b0;
            clamped_q   <= 1'b0;
            err_q       <= 1'b0;
            collision_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CHARS; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            rd_valid_q  <= rd_valid_d;
            clamped_q   <= clamped_d;
            err_q       <= err_d;
            collision_q <= collision_d;
        end
    end

    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign rd_valid  = rd_valid_q;
    assign clamped   = clamped_q;
    assign err       = err_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_character_position_file.sv
// Randomised check of character_position_file against an array-based reference model;
// collision expectations follow COLLISION_DETECT_EN.
module tb_character_position_file;

    logic       clock_50 = 1'b0;
    logic       reset    = 1'b0;
    logic [1:0] op       = 2'b00;
    logic [2:0] char_sel = 3'd0;
    logic [7:0] x_in     = 8'd0;
    logic [7:0] y_in     = 8'd0;
    logic [1:0] dir      = 2'b00;
    logic [7:0] x_out, y_out;
    logic       rd_valid, clamped, err;
    logic [3:0] collision;

    character_position_file #(
        .NUM_CHARS(5),
        .SEL_W(3),
        .COORD_W(8)
    ) dut (
        .clock_50 (clock_50),
        .reset    (reset),
        .op       (op),
        .char_sel (char_sel),
        .x_in     (x_in),
        .y_in     (y_in),
        .dir      (dir),
        .x_out    (x_out),
        .y_out    (y_out),
        .rd_valid (rd_valid),
        .clamped  (clamped),
        .err      (err),
        .collision(collision)
    );

    always #5 clock_50 = ~clock_50;

    int errors = 0;
    int checks = 0;

    // Reference model: plain integer positions and expected output values.
    int mx[5], my[5];
    int ex_x, ex_y, ex_rd, ex_cl, ex_err, ex_coll;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit rst_i, input int o, input int s, input int xi, input int yi, input int d);
        int c, mx_lim;
        ex_rd  = 0;
        ex_cl  = 0;
        ex_err = 0;
        if (rst_i) begin
            mx[0] = 10; my[0] = 10;
            for (int g = 1; g < 5; g++) begin
                mx[g] = 40 + (g - 1) * 5;
                my[g] = 35;
            end
            ex_x = 0; ex_y = 0; ex_coll = 0;
            return;
        end
        ex_coll = 0;
`ifdef COLLISION_DETECT_EN
        for (int g = 1; g < 5; g++)
            if (mx[g] == mx[0] && my[g] == my[0]) ex_coll |= (1 << (g - 1));
`endif
        if (o == 0) return;
        if (s >= 5) begin
            ex_err = 1;
            return;
        end
        case (o)
            1: begin
                ex_rd = 1; ex_x = mx[s]; ex_y = my[s];
            end
            2: begin
                ex_cl = (xi > 159 || yi > 119) ? 1 : 0;
                mx[s] = (xi > 159) ? 159 : xi;
                my[s] = (yi > 119) ? 119 : yi;
            end
            default: begin
                c      = (d < 2) ? my[s] : mx[s];
                mx_lim = (d < 2) ? 119 : 159;
                if (d == 0 || d == 2) begin
                    if (c < 1) begin c = 0; ex_cl = 1; end
                    else c = c - 1;
                end else begin
                    if (c + 1 > mx_lim) begin c = mx_lim; ex_cl = 1; end
                    else c = c + 1;
                end
                if (d < 2) my[s] = c; else mx[s] = c;
                ex_rd = 1; ex_x = mx[s]; ex_y = my[s];
            end
        endcase
    endtask

    task automatic do_op(input bit rst_i, input int o, input int s, input int xi, input int yi, input int d);
        @(negedge clock_50);
        reset    = rst_i;
        op       = o[1:0];
        char_sel = s[2:0];
        x_in     = xi[7:0];
        y_in     = yi[7:0];
        dir      = d[1:0];
        model(rst_i, o, s, xi, yi, d);
        @(posedge clock_50);
        #1;
        check("rd_valid",  rd_valid,  ex_rd);
        check("clamped",   clamped,   ex_cl);
        check("err",       err,       ex_err);
        check("x_out",     x_out,     ex_x);
        check("y_out",     y_out,     ex_y);
        check("collision", collision, ex_coll);
    endtask

    function automatic int pick_coord();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return 1;
            2: return 159;
            3: return 119;
            4: return $urandom_range(120, 255);
            default: return $urandom_range(0, 255);
        endcase
    endfunction

    initial begin
        int o, s;
        do_op(1, 0, 0, 0, 0, 0);
        do_op(0, 0, 0, 0, 0, 0);

        // Reset positions read back in order.
        for (int i = 0; i < 5; i++) do_op(0, 1, i, 0, 0, 0);
        check("last_read_x", x_out, 55);
        check("last_read_y", y_out, 35);

        do_op(0, 2, 2, 70, 60, 0);
        do_op(0, 1, 2, 0, 0, 0);
        check("rw_x", x_out, 70);
        check("rw_y", y_out, 60);
        do_op(0, 2, 1, 200, 130, 0);
        check("wr_clamp", clamped, 1);
        do_op(0, 1, 1, 0, 0, 0);
        check("clamp_x", x_out, 159);
        check("clamp_y", y_out, 119);

        do_op(0, 3, 0, 0, 0, 2);
        check("step_left_x", x_out, 9);
        do_op(0, 2, 0, 0, 0, 0);
        do_op(0, 3, 0, 0, 0, 0);
        check("step_up_clamp", clamped, 1);
        do_op(0, 2, 0, 159, 5, 0);
        do_op(0, 3, 0, 0, 0, 3);
        check("step_right_x", x_out, 159);

        do_op(0, 2, 5, 1, 1, 0);
        check("err_sel5", err, 1);
        do_op(0, 3, 7, 0, 0, 1);
        do_op(0, 1, 6, 0, 0, 0);
        for (int i = 0; i < 5; i++) do_op(0, 1, i, 0, 0, 0);

        // Reset wins over a same-cycle write.
        do_op(1, 2, 0, 99, 99, 0);
        do_op(0, 1, 0, 0, 0, 0);
        check("rst_over_wr_x", x_out, 10);
        check("rst_over_wr_y", y_out, 10);

        do_op(0, 2, 3, 10, 10, 0);
        do_op(0, 0, 0, 0, 0, 0);
`ifdef COLLISION_DETECT_EN
        check("coll_ghost3", collision, 4'b0100);
`else
        check("coll_off", collision, 0);
`endif
        do_op(0, 3, 0, 0, 0, 3);
        do_op(0, 0, 0, 0, 0, 0);
        check("coll_cleared", collision, 0);

        for (int n = 0; n < 600; n++) begin
            o = $urandom_range(0, 3);
            s = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
            do_op($urandom_range(0, 59) == 0, o, s, pick_coord(), pick_coord(), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/character_position_file.md
Name: character_position_file

Overview:
Parametrised register file holding pixel coordinates (x, y) for pacman (index 0) and NUM_CHARS-1 ghosts. Supports read, write and single-step directional move with boundary clamping, one operation per cycle. All results appear one cycle after the request, qualified by rd_valid. Sits between the game-logic FSMs (movement/AI) and the renderer/collision logic.

Parameters:
NUM_CHARS, 5, number of characters; index 0 = pacman, 1..NUM_CHARS-1 = ghosts
SEL_W, 3, width of char_sel; must satisfy 2**SEL_W >= NUM_CHARS
COORD_W, 8, coordinate width in bits
MAX_X, 159, largest legal x (pixels)
MAX_Y, 119, largest legal y (pixels)
STEP, 1, pixels moved per step op
PAC_X, 10, pacman reset x
PAC_Y, 10, pacman reset y
GHOST_X0, 40, ghost 1 reset x
GHOST_DX, 5, x spacing between consecutive ghosts at reset
GHOST_Y, 35, reset y for all ghosts

Ports:
clock_50  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
op  in  2  00 nop, 01 read, 10 write, 11 step
char_sel  in  SEL_W  target character index
x_in  in  COORD_W  write data x
y_in  in  COORD_W  write data y
dir  in  2  step direction: 00 up (y-STEP), 01 down (y+STEP), 10 left (x-STEP), 11 right (x+STEP)
x_out  out  COORD_W  result x; valid when rd_valid=1
y_out  out  COORD_W  result y; valid when rd_valid=1
rd_valid  out  1  one-cycle pulse: result of read/step present on x_out/y_out
clamped  out  1  one-cycle pulse: last write/step was clamped to bounds
err  out  1  one-cycle pulse: last op had char_sel >= NUM_CHARS
collision  out  NUM_CHARS-1  bit i-1 set when ghost i coincides with pacman (see Optional Feature)

Behaviour:
- Reset is sampled only at rising edge of clock_50: char 0 <- (PAC_X, PAC_Y); ghost i <- (GHOST_X0 + (i-1)*GHOST_DX, GHOST_Y). x_out=0, y_out=0, rd_valid=0, clamped=0, err=0, collision=0. Reset overrides any op in the same cycle. Reset during a pending op cancels it; no output pulses in the following cycle.
- Each cycle one op is registered. rd_valid, clamped and err are driven low in every cycle except the one that reports an op.
- nop: no state change. x_out/y_out hold their last values.
- read: next cycle rd_valid=1 and x_out/y_out = stored coords of char_sel.
- write: stored value becomes min(x_in, MAX_X), min(y_in, MAX_Y). Next cycle clamped=1 if either value was reduced. rd_valid=0 and x_out/y_out hold.
- step: compute at COORD_W+1 bits. Up/left with coord < STEP gives 0. Down/right with coord+STEP > MAX gives MAX. Either case sets clamped=1 in the next cycle. Only the axis given by dir changes. Next cycle rd_valid=1 and x_out/y_out = post-step coords.
- Read-after-write: an op issued in the cycle after a write to the same index sees the new value. No bypass is needed because the write commits at the edge.
- char_sel >= NUM_CHARS with op != nop: no state change, err=1 next cycle, rd_valid=0, clamped=0, outputs hold.
- Back-to-back ops are allowed every cycle. Throughput is 1 op/cycle and latency is 1 cycle.

Optional Feature:
COLLISION_DETECT_EN
- Defined: each cycle, collision[i-1] is registered as (ghost i x == pacman x) && (ghost i y == pacman y), using the stored contents before that edge. The output therefore lags state by 1 cycle after an update and is combined with no op.
- Undefined: no comparators are built and collision is tied to 0. The port is present in both builds.

Test Plan:
- Reset, then read sel 0..4 on consecutive cycles -> rd_valid=1 each following cycle with (10,10), (40,35), (45,35), (50,35), (55,35).
- Write sel 2 (70,60), next cycle read sel 2 -> (70,60), rd_valid=1, clamped=0. Write sel 1 (200,130) -> clamped=1, then read gives (159,119).
- Step sel 0: left from (10,10) -> (9,10). Write (0,0), step up -> (0,0), clamped=1. Write (159,5), step right -> (159,5), clamped=1.
- Any op with sel 5 or 7 -> err=1 one cycle, rd_valid=0, all stored coords unchanged on subsequent reads.
- Assert reset in the same cycle as write sel 0 (99,99) -> next read of sel 0 gives (10,10). No rd_valid/clamped/err pulse in the cycle after reset.
- With COLLISION_DETECT_EN: write sel 3 (10,10) -> collision=4'b0100 two cycles after the write op. Step pacman right -> collision=0 two cycles after the step. Without the macro, collision=0 throughout.
